fetch_req_ctrl: RTL and testbench
=================================

# fetch_req_ctrl

Fetch-request controller between the PC-select logic and the instruction cache's request/response port. It owns the fetch PC and sequences one outstanding instruction request at a time. It drops responses belonging to flushed requests and presents a registered one- or two-instruction bundle to the IF stage. It applies exception and branch redirects in any state, and never issues a request for a misaligned PC.

## Interface
Parameters:
- `RESET_PC`, default `32'h1c00_0000`: fetch PC loaded on reset.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `excep_flush_i`  in  1  exception/ertn redirect.
- `excep_pc_i`  in  32  exception redirect target.
- `branch_flush_i`  in  1  branch mispredict redirect.
- `branch_pc_i`  in  32  branch redirect target.
- `pr_taken_i`  in  1  predictor says the current bundle is taken.
- `pr_pc_i`  in  32  predicted target.
- `pre_uncache_i`  in  1  predicted uncached fetch; forces single-instruction fetch.
- `inst_req_o`  out  1  request to the icache.
- `inst_addr_o`  out  32  request address (the fetch PC).
- `inst_uncache_o`  out  1  uncached attribute of the request.
- `inst_addr_ok_i`  in  1  request accepted.
- `inst_data_ok_i`  in  1  response valid.
- `inst_rdata_i`  in  64  response data: `[31:0]` holds inst at PC, `[63:32]` holds PC+4.
- `next_allowin_i`  in  1  IF stage accepts the bundle.
- `if_valid_o`  out  1  bundle valid.
- `if_pc_o`  out  32  PC of inst1.
- `if_inst1_o`  out  32  first instruction.
- `if_inst2_o`  out  32  second instruction.
- `if_inst2_en_o`  out  1  inst2 valid.
- `if_adef_o`  out  1  fetch-address error; bundle carries no instruction.

## Operation
States: IDLE, REQ, WAIT, HOLD, HALT. A `discard` flag is used in WAIT.

Redirects:
- Redirect = `excep_flush_i | branch_flush_i`. Exception has priority over branch.
- In every state a redirect loads `pc` with its target and clears `if_valid_o`.
- IDLE, HOLD, HALT → REQ on a redirect.
- REQ stays in REQ with the new address on a redirect.
- WAIT stays in WAIT on a redirect and sets `discard`.

IDLE:
- Entered from reset. Moves to REQ on the next cycle.

REQ:
- If `pc[1:0]!=0`: `inst_req_o`=0, go to HOLD with `if_adef_o`=1, `if_inst2_en_o`=0, and instruction outputs all zero.
- Otherwise `inst_req_o`=1, `inst_addr_o`=`pc`, `inst_uncache_o`=`pre_uncache_i`. The address may change while `inst_addr_ok_i`=0.
- On `inst_addr_ok_i`, go to WAIT.
- If a redirect coincides with `inst_addr_ok_i`, the request counts as issued: go to WAIT with `discard`=1 and the new `pc`.

WAIT:
- On `inst_data_ok_i` with `discard`=0: register the bundle and go to HOLD.
- `if_inst2_en_o` = `~uncache_q & ~pc[2]`, where `uncache_q` is latched at addr_ok.
- On `inst_data_ok_i` with `discard`=1: drop the data, clear `discard`, go to REQ.
- A redirect in the same cycle as `data_ok` is treated as discard.

HOLD:
- `if_valid_o`=1.
- On `next_allowin_i` and no redirect, next `pc` is:
  - `pr_pc_i` if `pr_taken_i`;
  - else `pc+4` if `uncache_q` or `pc[2]`;
  - else `pc+8`.
- Then go to REQ. An adef bundle goes to HALT instead.

HALT:
- No requests are issued. Only a redirect exits HALT.

Arithmetic: 32-bit, wraps modulo 2^32.

## Timing
- Reset values: `pc`=`RESET_PC`, state IDLE, `discard`=0. Every output is 0 except `inst_addr_o`=`RESET_PC`.
- First `inst_req_o` is asserted in the 2nd cycle after `rst` deasserts.
- `addr_ok` at cycle t moves the state to WAIT at t+1.
- `data_ok` at cycle t drives `if_valid_o`=1 at t+1.
- Consume at cycle t drives the next `inst_req_o` at t+1.
- Best-case throughput is one bundle per 3 cycles.
- Outputs to IF are registered. `inst_req_o`/`inst_addr_o` are registered state plus `pc`.
- A redirect at cycle t makes `inst_addr_o`=target at t+1 and `if_valid_o`=0 at t+1.
- At most one request is outstanding. `data_ok` is ignored outside WAIT.

## Configuration
- `FETCH_PAIR_EN` defined:
  - Dual-instruction fetch as described.
- `FETCH_PAIR_EN` undefined:
  - `if_inst2_en_o` is always 0 and `if_inst2_o` is 0.
  - Sequential next PC is always `pc+4`.
  - `inst_rdata_i[63:32]` is ignored.

## Test plan
- Reset release with `addr_ok`/`data_ok` one cycle after request: first request address `0x1c000000`, bundle valid at cycle 4. Then `pc`=`0x1c000008` and `if_inst2_en_o`=1.
- Fetch at `0x1c000004`: `if_inst2_en_o`=0 and next address is `0x1c000008`. With `pre_uncache_i`=1 at `0x1c000000`: `inst_uncache_o`=1, inst2 disabled, next address `0x1c000004`.
- `branch_flush_i` to `0x1c000100` while in WAIT: the stale `data_ok` produces no `if_valid_o`, and the next request is issued to `0x1c000100`.
- `excep_flush_i` (`0x1c008000`) and `branch_flush_i` (`0x1c000100`) asserted together in REQ with `addr_ok` in the same cycle: WAIT with discard set, then the next request goes to `0x1c008000`.
- Redirect to `0x1c000102`: no `inst_req_o`, `if_adef_o`=1 bundle presented. After consume the block stays in HALT until `excep_flush_i` to `0x1c00c000`.
- Hold `next_allowin_i`=0 for 5 cycles in HOLD: bundle stable and no new request. With `pr_taken_i`=1 and `pr_pc_i`=`0x1c000200` at consume: next request is to `0x1c000200`.

Source files
------------

// File: rtl/fetch_req_ctrl.sv
// Fetch-request controller: owns the fetch PC, keeps one icache request in flight and
// presents a registered one- or two-instruction bundle to IF. Macro FETCH_PAIR_EN enables dual fetch.
module fetch_req_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        excep_flush_i,
    input  logic [31:0] excep_pc_i,
    input  logic        branch_flush_i,
    input  logic [31:0] branch_pc_i,
    input  logic        pr_taken_i,
    input  logic [31:0] pr_pc_i,
    input  logic        pre_uncache_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_uncache_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [63:0] inst_rdata_i,
    input  logic        next_allowin_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst1_o,
    output logic [31:0] if_inst2_o,
    output logic        if_inst2_en_o,
    output logic        if_adef_o
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        uncache_q, uncache_d;
    logic        valid_q, valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] inst1_q, inst1_d;
    logic [31:0] inst2_q, inst2_d;
    logic        inst2_en_q, inst2_en_d;
    logic        adef_q, adef_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        aligned;
    logic [31:0] seq_pc;

    assign redirect    = excep_flush_i | branch_flush_i;
    assign redirect_pc = excep_flush_i ? excep_pc_i : branch_pc_i;
    assign aligned     = (pc_q[1:0] == 2'b00);

`ifdef FETCH_PAIR_EN
    assign seq_pc = (uncache_q | pc_q[2]) ? pc_q + 32'd4 : pc_q + 32'd8;
`else
    assign seq_pc = pc_q + 32'd4;
    logic unused_pair;
    assign unused_pair = ^{1'b0, inst_rdata_i[63:32], uncache_q};
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        uncache_d  = uncache_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        inst1_d    = inst1_q;
        inst2_d    = inst2_q;
        inst2_en_d = inst2_en_q;
        adef_d     = adef_q;

        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (!aligned) begin
                    if (!redirect) begin
                        state_d    = S_HOLD;
                        valid_d    = 1'b1;
                        adef_d     = 1'b1;
                        if_pc_d    = pc_q;
                        inst1_d    = '0;
                        inst2_d    = '0;
                        inst2_en_d = 1'b0;
                    end
                end else if (inst_addr_ok_i) begin
                    // Accepted request is in flight even if a redirect lands now
                    state_d   = S_WAIT;
                    uncache_d = pre_uncache_i;
                    discard_d = redirect;
                end
            end
            S_WAIT: begin
                if (inst_data_ok_i) begin
                    if (discard_q || redirect) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                        adef_d  = 1'b0;
                        if_pc_d = pc_q;
                        inst1_d = inst_rdata_i[31:0];
`ifdef FETCH_PAIR_EN
                        inst2_d    = inst_rdata_i[63:32];
                        inst2_en_d = ~uncache_q & ~pc_q[2];
`else
                        inst2_d    = '0;
                        inst2_en_d = 1'b0;
`endif
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (next_allowin_i) begin
                    valid_d = 1'b0;
                    if (adef_q) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                        pc_d    = pr_taken_i ? pr_pc_i : seq_pc;
                    end
                end
            end
            S_HALT: if (redirect) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            uncache_q  <= 1'b0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            inst1_q    <= '0;
            inst2_q    <= '0;
            inst2_en_q <= 1'b0;
            adef_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            uncache_q  <= uncache_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            inst1_q    <= inst1_d;
            inst2_q    <= inst2_d;
            inst2_en_q <= inst2_en_d;
            adef_q     <= adef_d;
        end
    end

    assign inst_req_o     = (state_q == S_REQ) && aligned;
    assign inst_addr_o    = pc_q;
    assign inst_uncache_o = inst_req_o & pre_uncache_i;
    assign if_valid_o     = valid_q;
    assign if_pc_o        = if_pc_q;
    assign if_inst1_o     = inst1_q;
    assign if_inst2_o     = inst2_q;
    assign if_inst2_en_o  = inst2_en_q;
    assign if_adef_o      = adef_q;

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed bench for fetch_req_ctrl; expectations follow FETCH_PAIR_EN when it is defined.
module tb_fetch_req_ctrl;

`ifdef FETCH_PAIR_EN
    localparam bit PAIR = 1'b1;
`else
    localparam bit PAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        excep_flush_i, branch_flush_i, pr_taken_i, pre_uncache_i;
    logic [31:0] excep_pc_i, branch_pc_i, pr_pc_i;
    logic        inst_req_o, inst_uncache_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i, inst_data_ok_i;
    logic [63:0] inst_rdata_i;
    logic        next_allowin_i;
    logic        if_valid_o, if_inst2_en_o, if_adef_o;
    logic [31:0] if_pc_o, if_inst1_o, if_inst2_o;

    int checks = 0;
    int errors = 0;

    fetch_req_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .excep_flush_i  (excep_flush_i),
        .excep_pc_i     (excep_pc_i),
        .branch_flush_i (branch_flush_i),
        .branch_pc_i    (branch_pc_i),
        .pr_taken_i     (pr_taken_i),
        .pr_pc_i        (pr_pc_i),
        .pre_uncache_i  (pre_uncache_i),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_uncache_o (inst_uncache_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .next_allowin_i (next_allowin_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_inst1_o     (if_inst1_o),
        .if_inst2_o     (if_inst2_o),
        .if_inst2_en_o  (if_inst2_en_o),
        .if_adef_o      (if_adef_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From REQ: accept the request, then return data one cycle later; ends in HOLD.
    task automatic fetch(input logic [63:0] data);
        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = data;
        step();
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = '0;
    endtask

    task automatic consume();
        next_allowin_i = 1'b1;
        step();
        next_allowin_i = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] target);
        branch_flush_i = 1'b1;
        branch_pc_i    = target;
        step();
        branch_flush_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        excep_flush_i = 1'b0; branch_flush_i = 1'b0; pr_taken_i = 1'b0;
        excep_pc_i = '0; branch_pc_i = '0; pr_pc_i = '0;
        pre_uncache_i = 1'b1;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
        next_allowin_i = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_req", inst_req_o, 0);
        chk("rst_addr", inst_addr_o, 32'h1c00_0000);
        chk("rst_uncache", inst_uncache_o, 0);
        chk("rst_valid", if_valid_o, 0);
        chk("rst_if_pc", if_pc_o, 0);
        chk("rst_inst1", if_inst1_o, 0);
        chk("rst_inst2_en", if_inst2_en_o, 0);
        chk("rst_adef", if_adef_o, 0);

        pre_uncache_i = 1'b0;
        rst = 1'b0;
        chk("idle_req", inst_req_o, 0);
        step();
        chk("first_req", inst_req_o, 1);
        chk("first_addr", inst_addr_o, 32'h1c00_0000);

        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        chk("wait_req", inst_req_o, 0);
        chk("wait_valid", if_valid_o, 0);
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 64'h2222_2222_1111_1111;
        step();
        inst_data_ok_i = 1'b0;
        chk("b1_valid", if_valid_o, 1);
        chk("b1_pc", if_pc_o, 32'h1c00_0000);
        chk("b1_inst1", if_inst1_o, 32'h1111_1111);
        chk("b1_inst2", if_inst2_o, PAIR ? 32'h2222_2222 : 32'h0);
        chk("b1_inst2_en", if_inst2_en_o, PAIR);
        chk("b1_adef", if_adef_o, 0);

        // HOLD stalls: bundle stable, no request; late data_ok ignored
        for (int i = 0; i < 5; i++) begin
            inst_data_ok_i = (i == 2);
            inst_rdata_i   = 64'hdead_beef_dead_beef;
            step();
            chk("stall_valid", if_valid_o, 1);
            chk("stall_req", inst_req_o, 0);
            chk("stall_inst1", if_inst1_o, 32'h1111_1111);
        end
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = '0;
        consume();
        chk("b1_next_req", inst_req_o, 1);
        chk("b1_next_addr", inst_addr_o, PAIR ? 32'h1c00_0008 : 32'h1c00_0004);
        chk("b1_next_valid", if_valid_o, 0);

        // Fetch at PC+4 half of a pair
        branch_to(32'h1c00_0004);
        chk("redir_req_addr", inst_addr_o, 32'h1c00_0004);
        chk("redir_req_req", inst_req_o, 1);
        fetch(64'h4444_4444_3333_3333);
        chk("b2_pc", if_pc_o, 32'h1c00_0004);
        chk("b2_inst1", if_inst1_o, 32'h3333_3333);
        chk("b2_inst2_en", if_inst2_en_o, 0);
        consume();
        chk("b2_next_addr", inst_addr_o, 32'h1c00_0008);

        // Uncached fetch
        pre_uncache_i = 1'b1;
        branch_to(32'h1c00_0000);
        chk("unc_attr", inst_uncache_o, 1);
        chk("unc_addr", inst_addr_o, 32'h1c00_0000);
        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        pre_uncache_i  = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 64'h6666_6666_5555_5555;
        step();
        inst_data_ok_i = 1'b0;
        chk("unc_valid", if_valid_o, 1);
        chk("unc_inst2_en", if_inst2_en_o, 0);
        consume();
        chk("unc_next_addr", inst_addr_o, 32'h1c00_0004);

        // Branch redirect while WAIT: stale response dropped
        inst_addr_ok_i = 1'b1;
        step();
        inst_addr_ok_i = 1'b0;
        branch_to(32'h1c00_0100);
        chk("wflush_addr", inst_addr_o, 32'h1c00_0100);
        chk("wflush_req", inst_req_o, 0);
        inst_data_ok_i = 1'b1;
        step();
        inst_data_ok_i = 1'b0;
        chk("wflush_valid", if_valid_o, 0);
        chk("wflush_req2", inst_req_o, 1);
        chk("wflush_addr2", inst_addr_o, 32'h1c00_0100);

        // Exception beats branch, coincident with addr_ok
        excep_flush_i = 1'b1; excep_pc_i = 32'h1c00_8000;
        branch_flush_i = 1'b1; branch_pc_i = 32'h1c00_0100;
        inst_addr_ok_i = 1'b1;
        step();
        excep_flush_i = 1'b0; branch_flush_i = 1'b0; inst_addr_ok_i = 1'b0;
        chk("xb_req", inst_req_o, 0);
        chk("xb_addr", inst_addr_o, 32'h1c00_8000);
        inst_data_ok_i = 1'b1;
        step();
        inst_data_ok_i = 1'b0;
        chk("xb_valid", if_valid_o, 0);
        chk("xb_req2", inst_req_o, 1);
        chk("xb_addr2", inst_addr_o, 32'h1c00_8000);

        // Predicted-taken consume
        fetch(64'h8888_8888_7777_7777);
        chk("pr_valid", if_valid_o, 1);
        chk("pr_pc", if_pc_o, 32'h1c00_8000);
        pr_taken_i = 1'b1; pr_pc_i = 32'h1c00_0200;
        consume();
        pr_taken_i = 1'b0;
        chk("pr_next_addr", inst_addr_o, 32'h1c00_0200);
        chk("pr_next_req", inst_req_o, 1);

        // Misaligned redirect -> adef bundle -> HALT
        branch_to(32'h1c00_0102);
        chk("adef_noreq", inst_req_o, 0);
        chk("adef_addr", inst_addr_o, 32'h1c00_0102);
        step();
        chk("adef_valid", if_valid_o, 1);
        chk("adef_flag", if_adef_o, 1);
        chk("adef_inst1", if_inst1_o, 0);
        chk("adef_inst2", if_inst2_o, 0);
        chk("adef_inst2_en", if_inst2_en_o, 0);
        chk("adef_pc", if_pc_o, 32'h1c00_0102);
        consume();
        for (int i = 0; i < 4; i++) begin
            inst_addr_ok_i = 1'b1;
            inst_data_ok_i = 1'b1;
            step();
            chk("halt_req", inst_req_o, 0);
            chk("halt_valid", if_valid_o, 0);
        end
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        excep_flush_i = 1'b1; excep_pc_i = 32'h1c00_c000;
        step();
        excep_flush_i = 1'b0;
        chk("halt_exit_req", inst_req_o, 1);
        chk("halt_exit_addr", inst_addr_o, 32'h1c00_c000);
        fetch(64'haaaa_aaaa_9999_9999);
        chk("post_valid", if_valid_o, 1);
        chk("post_adef", if_adef_o, 0);
        chk("post_inst1", if_inst1_o, 32'h9999_9999);
        chk("post_inst2_en", if_inst2_en_o, PAIR);

        // Redirect in HOLD clears the bundle
        branch_to(32'h1c00_0040);
        chk("hold_flush_valid", if_valid_o, 0);
        chk("hold_flush_req", inst_req_o, 1);
        chk("hold_flush_addr", inst_addr_o, 32'h1c00_0040);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
